vote_input_conditioner: RTL and testbench

// - Upstream stage for the 3-input minority voter: conditions three raw, asynchronous

---
 rtl/vote_input_conditioner.sv | 100 ++++++++++
 tb/tb_vote_input_conditioner.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vote_input_conditioner.sv
// Conditions three asynchronous voter inputs into synchronized, debounced A/B/C bits
// with a one-cycle strobe on every accepted change. Define VOTE_CHG_CNT_EN to add chg_cnt.
module vote_input_conditioner #(
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             raw_a,
    input  logic             raw_b,
    input  logic             raw_c,
    input  logic             sample_en,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             abc_valid
`ifdef VOTE_CHG_CNT_EN
    ,
    output logic [CNT_W-1:0] chg_cnt
`endif
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    if (DEBOUNCE < 1 || CNT_W < 1) begin : g_param_check
        $error("vote_input_conditioner: DEBOUNCE and CNT_W must both be >= 1");
    end

    // Bit 2 = A, bit 1 = B, bit 0 = C throughout.
    logic [2:0] raw_vec;
    logic [2:0] held_vec;
    logic [2:0] accept_vec;
    logic       abc_valid_reg;

    assign raw_vec = {raw_a, raw_b, raw_c};

    for (genvar gi = 0; gi < 3; gi++) begin : g_bit
        logic          s1_reg;
        logic          s2_reg;
        logic          h_reg;
        logic [CW-1:0] cnt_reg;
        logic          accept;

        // The change is taken on the edge that would complete DEBOUNCE differing samples.
        assign accept = sample_en && (s2_reg != h_reg) && (cnt_reg == CW'(DEBOUNCE - 1));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_reg  <= 1'b0;
                s2_reg  <= 1'b0;
                h_reg   <= 1'b0;
                cnt_reg <= '0;
            end else begin
                s1_reg <= raw_vec[gi];
                s2_reg <= s1_reg;
                if (!sample_en || (s2_reg == h_reg)) begin
                    cnt_reg <= '0;
                end else if (accept) begin
                    h_reg   <= s2_reg;
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end

        assign held_vec[gi]   = h_reg;
        assign accept_vec[gi] = accept;
    end

    // Registered on the same edge as the held bits, so the strobe lines up with new outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abc_valid_reg <= 1'b0;
        end else begin
            abc_valid_reg <= |accept_vec;
        end
    end

    assign a         = held_vec[2];
    assign b         = held_vec[1];
    assign c         = held_vec[0];
    assign abc_valid = abc_valid_reg;

`ifdef VOTE_CHG_CNT_EN
    logic [CNT_W-1:0] chg_cnt_reg;

    // One count per strobe, saturating rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg_cnt_reg <= '0;
        end else if ((|accept_vec) && (chg_cnt_reg != {CNT_W{1'b1}})) begin
            chg_cnt_reg <= chg_cnt_reg + 1'b1;
        end
    end

    assign chg_cnt = chg_cnt_reg;
`endif

endmodule

// File: tb/tb_vote_input_conditioner.sv
// Bench for vote_input_conditioner: directed scenarios plus randomized traffic checked
// every cycle against a sliding-window reference model.
module tb_vote_input_conditioner;

    localparam int DEB   = 4;
    localparam int CNT_T = 2;
    localparam int MAXE  = 8192;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic raw_a = 1'b0, raw_b = 1'b0, raw_c = 1'b0;
    logic sample_en = 1'b1;
    logic a, b, c, abc_valid;
`ifdef VOTE_CHG_CNT_EN
    logic [CNT_T-1:0] chg_cnt;
`endif

    int total = 0;
    int bad   = 0;

    vote_input_conditioner #(.DEBOUNCE(DEB), .CNT_W(CNT_T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw_a     (raw_a),
        .raw_b     (raw_b),
        .raw_c     (raw_c),
        .sample_en (sample_en),
        .a         (a),
        .b         (b),
        .c         (c),
        .abc_valid (abc_valid)
`ifdef VOTE_CHG_CNT_EN
        ,
        .chg_cnt   (chg_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: per-edge history since reset; a bit flips when the last DEB edges
    // (all after its previous flip) had sampling enabled and a synchronized value != held.
    logic [2:0] raw_hist [MAXE];
    logic       en_hist  [MAXE];
    int         edge_n;
    int         last_acc [3];
    logic [2:0] exp_h;
    logic       exp_valid;
    int         exp_cnt;

    function automatic logic [2:0] s2_at(input int m);
        return (m >= 2) ? raw_hist[m-2] : 3'b000;
    endfunction

    task automatic model_step();
        logic [2:0] acc;
        logic [2:0] sv;
        bit ok;
        if (!rst_n) begin
            edge_n = 0;
            for (int x = 0; x < 3; x++) last_acc[x] = -1;
            exp_h = 3'b000;
            exp_valid = 1'b0;
            exp_cnt = 0;
        end else begin
            acc = 3'b000;
            raw_hist[edge_n] = {raw_a, raw_b, raw_c};
            en_hist[edge_n]  = sample_en;
            for (int x = 0; x < 3; x++) begin
                if (edge_n - last_acc[x] >= DEB) begin
                    ok = 1;
                    for (int j = 0; j < DEB; j++) begin
                        sv = s2_at(edge_n - j);
                        if (!en_hist[edge_n - j] || sv[x] == exp_h[x]) ok = 0;
                    end
                    acc[x] = ok;
                end
            end
            for (int x = 0; x < 3; x++) begin
                if (acc[x]) begin
                    exp_h[x] = ~exp_h[x];
                    last_acc[x] = edge_n;
                end
            end
            exp_valid = |acc;
            if (exp_valid && exp_cnt < (2**CNT_T - 1)) exp_cnt = exp_cnt + 1;
            edge_n = edge_n + 1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Every-cycle comparison against the model (all zeros while reset is held).
    initial forever begin
        @(negedge clk);
        total = total + 1;
        if (!rst_n) begin
            if ({a, b, c, abc_valid} !== 4'b0000) begin
                bad = bad + 1;
                $display("FAIL cyc_rst t=%0t got abcv=%b want 0000", $time, {a, b, c, abc_valid});
            end
        end else if ({a, b, c, abc_valid} !== {exp_h, exp_valid}) begin
            bad = bad + 1;
            $display("FAIL cyc_abcv t=%0t got abcv=%b want %b", $time, {a, b, c, abc_valid}, {exp_h, exp_valid});
        end
`ifdef VOTE_CHG_CNT_EN
        total = total + 1;
        if (rst_n && (int'(chg_cnt) != exp_cnt)) begin
            bad = bad + 1;
            $display("FAIL cyc_chg_cnt t=%0t got %0d want %0d", $time, chg_cnt, exp_cnt);
        end
`endif
    end

    task automatic chk(input string name, input int act, input int want);
        total = total + 1;
        if (act != want) begin
            bad = bad + 1;
            $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_raw(input logic [2:0] r);
        {raw_a, raw_b, raw_c} = r;
    endtask

    task automatic do_reset(input logic [2:0] r);
        set_raw(r);
        rst_n = 1'b0;
        #1;
        chk("async_rst_abc", int'({a, b, c}), 0);
        chk("async_rst_valid", int'(abc_valid), 0);
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [2:0] r;
        tick(2);

        // Reset with all inputs high: nothing appears until the 6th edge after release.
        do_reset(3'b111);
        tick(5);  chk("rst_hold_abc", int'({a, b, c}), 0);
        tick(1);  chk("rst_first_abc", int'({a, b, c}), 7);
                  chk("rst_first_valid", int'(abc_valid), 1);
        tick(1);  chk("rst_valid_drop", int'(abc_valid), 0);

        // Single accepted change on A.
        do_reset(3'b000);
        tick(8);  chk("idle_abc", int'({a, b, c}), 0);
        set_raw(3'b100);
        tick(5);  chk("acc_before", int'({a, b, c}), 0);
        tick(1);  chk("acc_abc", int'({a, b, c}), 4);
                  chk("acc_valid", int'(abc_valid), 1);
        tick(1);  chk("acc_valid_drop", int'(abc_valid), 0);

        // Three-cycle glitch on B is rejected.
        set_raw(3'b110);
        tick(3);
        set_raw(3'b100);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("glitch_no_valid", int'(abc_valid), 0);
        end
        chk("glitch_abc", int'({a, b, c}), 4);

        // Simultaneous change on all three bits gives a single strobe.
        set_raw(3'b000);
        tick(8);  chk("back_to_zero", int'({a, b, c}), 0);
`ifdef VOTE_CHG_CNT_EN
        chk("cnt_two_changes", int'(chg_cnt), 2);
`endif
        set_raw(3'b111);
        tick(5);  chk("sim_before", int'({a, b, c}), 0);
        tick(1);  chk("sim_abc", int'({a, b, c}), 7);
                  chk("sim_valid", int'(abc_valid), 1);
`ifdef VOTE_CHG_CNT_EN
        chk("sim_cnt", int'(chg_cnt), 3);
`endif
        tick(1);  chk("sim_valid_drop", int'(abc_valid), 0);

        // Sampling disabled holds C; re-enabling restarts the full window.
        sample_en = 1'b0;
        set_raw(3'b110);
        tick(10); chk("hold_abc", int'({a, b, c}), 7);
        sample_en = 1'b1;
        tick(3);  chk("reen_partial", int'({a, b, c}), 7);
        tick(1);  chk("reen_abc", int'({a, b, c}), 6);
                  chk("reen_valid", int'(abc_valid), 1);

        // Reset in the middle of a debounce count.
        set_raw(3'b111);
        tick(3);
        do_reset(3'b111);
        chk("midrst_c", int'(c), 0);
        tick(5);  chk("midrst_before", int'({a, b, c}), 0);
        tick(1);  chk("midrst_abc", int'({a, b, c}), 7);

`ifdef VOTE_CHG_CNT_EN
        chk("cnt_after_rst", int'(chg_cnt), 1);
        set_raw(3'b011); tick(7);
        set_raw(3'b111); tick(7);
        set_raw(3'b011); tick(7);
        chk("cnt_saturate", int'(chg_cnt), 3);
`endif

        // Randomized traffic; the every-cycle compare process does the checking.
        r = {raw_a, raw_b, raw_c};
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                r = 3'($urandom_range(0, 7));
                do_reset(r);
            end else begin
                for (int x = 0; x < 3; x++)
                    if ($urandom_range(0, 7) == 0) r[x] = ~r[x];
                set_raw(r);
                sample_en = ($urandom_range(0, 15) != 0);
                tick(1);
            end
        end

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
